ex_unit: RTL

//  Execute stage; sits directly downstream of instruction decode.

---
 rtl/cpu_defs_pkg.sv | 35 +++
 rtl/ex_unit_div_iter.sv | 88 ++++++++
 rtl/ex_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: aluop encodings and the execute-stage divider state encoding.
package cpu_defs;

  localparam int unsigned AluOpW = 8;

  localparam logic [AluOpW-1:0] OpNop  = 8'h00;
  localparam logic [AluOpW-1:0] OpSrl  = 8'h02;
  localparam logic [AluOpW-1:0] OpSra  = 8'h03;
  localparam logic [AluOpW-1:0] OpMfhi = 8'h10;
  localparam logic [AluOpW-1:0] OpMthi = 8'h11;
  localparam logic [AluOpW-1:0] OpMflo = 8'h12;
  localparam logic [AluOpW-1:0] OpMtlo = 8'h13;
  localparam logic [AluOpW-1:0] OpDiv  = 8'h1A;
  localparam logic [AluOpW-1:0] OpDivu = 8'h1B;
  localparam logic [AluOpW-1:0] OpAddu = 8'h21;
  localparam logic [AluOpW-1:0] OpSubu = 8'h23;
  localparam logic [AluOpW-1:0] OpAnd  = 8'h24;
  localparam logic [AluOpW-1:0] OpOr   = 8'h25;
  localparam logic [AluOpW-1:0] OpXor  = 8'h26;
  localparam logic [AluOpW-1:0] OpNor  = 8'h27;
  localparam logic [AluOpW-1:0] OpSlt  = 8'h2A;
  localparam logic [AluOpW-1:0] OpSltu = 8'h2B;
  localparam logic [AluOpW-1:0] OpSll  = 8'h7C;

  typedef enum logic [1:0] {
    DivIdle = 2'd0,
    DivBusy = 2'd1,
    DivDone = 2'd2
  } div_state_e;

  function automatic logic is_div_op(input logic [AluOpW-1:0] op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

endpackage

// File: rtl/ex_unit_div_iter.sv
// Restoring shift-subtract divider datapath, one quotient bit per clock; sign fix-up on output.
module div_iter
  import cpu_defs::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              done_o,
  output logic [DATA_W-1:0] quo_o,
  output logic [DATA_W-1:0] rem_o
);

  localparam int unsigned CntW = $clog2(DATA_W);

  // Upper half: partial remainder; lower half: dividend shifting out / quotient shifting in.
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                run_q, run_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;

  logic [2*DATA_W:0]   shifted;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   a_abs, b_abs;

  assign a_abs   = (signed_op_i && a_i[DATA_W-1]) ? -a_i : a_i;
  assign b_abs   = (signed_op_i && b_i[DATA_W-1]) ? -b_i : b_i;
  assign shifted = {acc_q, 1'b0};
  assign diff    = shifted[2*DATA_W:DATA_W] - {1'b0, dvs_q};

  // High on the edge that performs the final step.
  assign done_o = run_q && (cnt_q == CntW'(DATA_W - 1));

  always_comb begin
    acc_d     = acc_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    run_d     = run_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (start_i) begin
      acc_d     = {{DATA_W{1'b0}}, a_abs};
      dvs_d     = b_abs;
      cnt_d     = '0;
      run_d     = 1'b1;
      neg_quo_d = signed_op_i && (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
      neg_rem_d = signed_op_i && a_i[DATA_W-1];
    end else if (run_q) begin
      if (!diff[DATA_W]) begin
        acc_d = {diff[DATA_W-1:0], shifted[DATA_W-1:1], 1'b1};
      end else begin
        acc_d = shifted[2*DATA_W-1:0];
      end
      cnt_d = cnt_q + 1'b1;
      if (done_o) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      run_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign quo_o = neg_quo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
  assign rem_o = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/ex_unit.sv
// Execute stage: registered decode outputs, ALU, HI/LO and (with EX_DIV_EN defined) an
// iterative divider that raises stallreq_o while it runs.
module ex_unit
  import cpu_defs::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned ALUOP_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [DATA_W-1:0]  reg1_i,
  input  logic [DATA_W-1:0]  reg2_i,
  input  logic               wreg_i,
  input  logic [REG_AW-1:0]  wd_i,
  output logic [DATA_W-1:0]  wdata_o,
  output logic [REG_AW-1:0]  wd_o,
  output logic               wreg_o,
  output logic               stallreq_o
);

`ifdef EX_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic [ALUOP_W-1:0] aluop_q;
  logic [DATA_W-1:0]  reg1_q, reg2_q;
  logic               wreg_q;
  logic [REG_AW-1:0]  wd_q;
  logic [DATA_W-1:0]  hi_q, hi_d, lo_q, lo_d;

  logic               div_hold;
  logic               div_stall;
  logic               div_commit;
  logic [DATA_W-1:0]  div_hi, div_lo;

  logic [DATA_W-1:0]  alu_res;
  logic               alu_wreg;
  logic [4:0]         shamt;

  // The divider keeps its own instruction latched until DONE, regardless of stall_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      aluop_q <= OpNop;
      reg1_q  <= '0;
      reg2_q  <= '0;
      wreg_q  <= 1'b0;
      wd_q    <= '0;
    end else if (!(stall_i || div_hold)) begin
      aluop_q <= aluop_i;
      reg1_q  <= reg1_i;
      reg2_q  <= reg2_i;
      wreg_q  <= wreg_i;
      wd_q    <= wd_i;
    end
  end

`ifdef EX_DIV_EN
  div_state_e        state_q, state_d;
  logic              div_start;
  logic              iter_done;
  logic [DATA_W-1:0] quo, rem;

  always_comb begin
    state_d    = state_q;
    div_start  = 1'b0;
    div_hold   = 1'b0;
    div_stall  = 1'b0;
    div_commit = 1'b0;
    unique case (state_q)
      DivIdle: begin
        if (is_div_op(aluop_q)) begin
          div_stall = 1'b1;
          div_hold  = 1'b1;
          if (reg2_q == '0) begin
            state_d = DivDone;
          end else begin
            div_start = 1'b1;
            state_d   = DivBusy;
          end
        end
      end
      DivBusy: begin
        div_stall = 1'b1;
        div_hold  = 1'b1;
        if (iter_done) begin
          state_d = DivDone;
        end
      end
      DivDone: begin
        if (!stall_i) begin
          div_commit = 1'b1;
          state_d    = DivIdle;
        end
      end
      default: state_d = DivIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DivIdle;
    end else begin
      state_q <= state_d;
    end
  end

  div_iter #(
    .DATA_W(DATA_W)
  ) u_div_iter (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .signed_op_i(aluop_q == OpDiv),
    .a_i        (reg1_q),
    .b_i        (reg2_q),
    .done_o     (iter_done),
    .quo_o      (quo),
    .rem_o      (rem)
  );

  // Operands stay latched through DONE, so divide-by-zero is recognised from reg2_q here.
  assign div_lo = (reg2_q == '0) ? '1 : quo;
  assign div_hi = (reg2_q == '0) ? reg1_q : rem;
`else
  assign div_hold   = 1'b0;
  assign div_stall  = 1'b0;
  assign div_commit = 1'b0;
  assign div_hi     = '0;
  assign div_lo     = '0;
`endif

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_commit) begin
      hi_d = div_hi;
      lo_d = div_lo;
    end else if (!stall_i) begin
      if (aluop_q == OpMthi) hi_d = reg1_q;
      if (aluop_q == OpMtlo) lo_d = reg1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign shamt = reg1_q[4:0];

  always_comb begin
    alu_res  = '0;
    alu_wreg = wreg_q;
    case (aluop_q)
      OpAnd:  alu_res = reg1_q & reg2_q;
      OpOr:   alu_res = reg1_q | reg2_q;
      OpXor:  alu_res = reg1_q ^ reg2_q;
      OpNor:  alu_res = ~(reg1_q | reg2_q);
      OpAddu: alu_res = reg1_q + reg2_q;
      OpSubu: alu_res = reg1_q - reg2_q;
      OpSlt:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(reg1_q) < $signed(reg2_q))};
      OpSltu: alu_res = {{(DATA_W-1){1'b0}}, (reg1_q < reg2_q)};
      OpSll:  alu_res = reg2_q << shamt;
      OpSrl:  alu_res = reg2_q >> shamt;
      OpSra:  alu_res = $signed(reg2_q) >>> shamt;
      OpMfhi: alu_res = hi_q;
      OpMflo: alu_res = lo_q;
      OpMthi, OpMtlo: alu_wreg = 1'b0;
      OpDiv, OpDivu:  alu_wreg = DivEn ? 1'b0 : wreg_q;
      OpNop: ;
      default: alu_wreg = 1'b0;
    endcase
  end

  assign wdata_o    = alu_res;
  assign wd_o       = wd_q;
  assign wreg_o     = alu_wreg & ~div_stall;
  assign stallreq_o = div_stall;

endmodule
